// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  // Per-stage control bits; the data fields are width-dependent and live in the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stg_ctl_t;

  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic bit seg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && (width % seg == 0);
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead slice: every carry is a flat P/G product term.
module cla_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_ci,
  output logic [SEG-1:0] o_sum,
  output logic           o_co,
  output logic           o_c_msb_in
);

  logic [SEG-1:0] w_p, w_g;
  logic [SEG:0]   w_c;
  logic           w_pp;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]ci, built from the top bit down
  always_comb begin
    w_c    = '0;
    w_pp   = 1'b1;
    w_c[0] = i_ci;
    for (int i = 1; i <= SEG; i++) begin
      w_pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i] = w_c[i] | (w_pp & w_g[j]);
        w_pp   = w_pp & w_p[j];
      end
      w_c[i] = w_c[i] | (w_pp & i_ci);
    end
  end

  assign o_sum      = w_p ^ w_c[SEG-1:0];
  assign o_co       = w_c[SEG];
  assign o_c_msb_in = w_c[SEG-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined add/sub: one SEG-bit lookahead segment per stage, carry registered between
// stages, global stall on output backpressure.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_ci,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSEG = nseg(WIDTH, SEG);

  if (!seg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  typedef struct packed {
    stg_ctl_t         ctl;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stg_t;

  stg_t r_stg [NSEG];
  stg_t w_src [NSEG];
  stg_t w_nxt [NSEG];

  logic [NSEG-1:0][SEG-1:0] w_seg_sum;
  logic [NSEG-1:0]          w_seg_co;
  logic [NSEG-1:0]          w_seg_cm;
  logic                     w_adv;

  assign w_adv    = !r_stg[NSEG-1].ctl.valid || out_ready;
  assign in_ready = w_adv;

  // Stage 0 sees the operands with B already conditioned for subtraction.
  always_comb begin
    for (int k = 0; k < NSEG; k++) w_src[k] = '0;
    w_src[0].ctl.valid = in_valid;
    w_src[0].ctl.carry = in_sub ? 1'b1 : in_ci;
    w_src[0].tag       = in_tag;
    w_src[0].a         = in_a;
    w_src[0].b         = in_sub ? ~in_b : in_b;
    for (int k = 1; k < NSEG; k++) w_src[k] = r_stg[k-1];
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    cla_segment #(.SEG(SEG)) u_seg (
      .i_a        (w_src[k].a[k*SEG +: SEG]),
      .i_b        (w_src[k].b[k*SEG +: SEG]),
      .i_ci       (w_src[k].ctl.carry),
      .o_sum      (w_seg_sum[k]),
      .o_co       (w_seg_co[k]),
      .o_c_msb_in (w_seg_cm[k])
    );
  end

  // Consumed operand segments are cleared so only the pending upper part travels on.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      w_nxt[k]                     = w_src[k];
      w_nxt[k].sum[k*SEG +: SEG]   = w_seg_sum[k];
      w_nxt[k].a[k*SEG +: SEG]     = '0;
      w_nxt[k].b[k*SEG +: SEG]     = '0;
      w_nxt[k].ctl.carry           = w_seg_co[k];
      w_nxt[k].ctl.ovf             = (k == NSEG - 1) ? (w_seg_co[k] ^ w_seg_cm[k]) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) r_stg[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < NSEG; k++) r_stg[k] <= w_nxt[k];
    end
  end

  assign out_valid = r_stg[NSEG-1].ctl.valid;
  assign out_sum   = r_stg[NSEG-1].sum;
  assign out_cout  = r_stg[NSEG-1].ctl.carry;
  assign out_ovf   = r_stg[NSEG-1].ctl.ovf;
  assign out_tag   = r_stg[NSEG-1].tag;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: three configurations (32/8, 24/8, 16/16) against an arithmetic model.
module tb_cla_addsub_pipe;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
    int          acc;
    int          st0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv [3], ir [3], isub [3], ici [3], ov [3], ordy [3], oc [3], oo [3];
  logic [31:0] ia [3], ib [3], os [3];
  logic [3:0]  itag [3], otag [3];

  int errs = 0, checks = 0;
  int n_cons [3], n_acc [3], qdep [3];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit numbers, signed range test for overflow.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic ci);
    res_t   r;
    longint m, ua, ub, sa, sb, full, ex, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    if (sub) begin
      full   = ua - ub;
      ex     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + longint'(ci);
      ex     = sa + sb + longint'(ci);
      r.cout = ((full >> w) & 1) != 0;
    end
    r.sum = 32'(full & m);
    r.ovf = (ex >= half) || (ex < -half);
    return r;
  endfunction

  function automatic int cw(input int i);
    return (i == 0) ? 32 : (i == 1) ? 24 : 16;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W  = (gi == 0) ? 32 : (gi == 1) ? 24 : 16;
    localparam int S  = (gi == 2) ? 16 : 8;
    localparam int NS = W / S;

    logic [W-1:0] w_sum;
    exp_t         q [$];
    int           cyc = 0, stalls = 0;
    logic         prev_stall = 1'b0;
    logic [38:0]  held = '0;

    cla_addsub_pipe #(.WIDTH(W), .SEG(S), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[gi]), .in_ready(ir[gi]),
      .in_a(ia[gi][W-1:0]), .in_b(ib[gi][W-1:0]),
      .in_sub(isub[gi]), .in_ci(ici[gi]), .in_tag(itag[gi]),
      .out_valid(ov[gi]), .out_ready(ordy[gi]),
      .out_sum(w_sum), .out_cout(oc[gi]), .out_ovf(oo[gi]), .out_tag(otag[gi])
    );
    assign os[gi] = 32'(w_sum);

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
        chk($sformatf("c%0d_rst_outs", gi), {ov[gi], oc[gi], oo[gi], otag[gi], os[gi]}, '0);
      end else begin
        chk($sformatf("c%0d_in_ready", gi), ir[gi], !ov[gi] || ordy[gi]);
        if (prev_stall)
          chk($sformatf("c%0d_hold", gi), {ov[gi], oc[gi], oo[gi], otag[gi], os[gi]}, held);
        if (ov[gi] && !prev_stall) begin
          chk($sformatf("c%0d_pending", gi), q.size() > 0, 1);
          if (q.size() > 0)
            chk($sformatf("c%0d_latency", gi), cyc, q[0].acc + NS + (stalls - q[0].st0));
        end
        if (ov[gi] && ordy[gi] && q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("c%0d_sum", gi), os[gi], e.sum);
          chk($sformatf("c%0d_cout_ovf_tag", gi), {oc[gi], oo[gi], otag[gi]}, {e.cout, e.ovf, e.tag});
          n_cons[gi]++;
        end
        prev_stall = ov[gi] && !ordy[gi];
        if (prev_stall) begin
          stalls++;
          held = {ov[gi], oc[gi], oo[gi], otag[gi], os[gi]};
        end
        if (iv[gi] && ir[gi]) begin
          res_t r;
          exp_t e;
          r = model(W, ia[gi], ib[gi], isub[gi], ici[gi]);
          e.sum = r.sum; e.cout = r.cout; e.ovf = r.ovf; e.tag = itag[gi];
          e.acc = cyc; e.st0 = stalls;
          q.push_back(e);
          n_acc[gi]++;
        end
      end
      qdep[gi] = q.size();
      cyc++;
    end
  end

  // Single op on config 0 with an idle pipe; checks exact latency and literal results.
  task automatic dir_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic ci, input logic [3:0] tag,
                        input logic [31:0] es, input logic ec, input logic eo);
    res_t r;
    r = model(32, a, b, sub, ci);
    chk({nm, "_model"}, {r.ovf, r.cout, r.sum}, {eo, ec, es});
    iv[0] = 1'b1; ia[0] = a; ib[0] = b; isub[0] = sub; ici[0] = ci; itag[0] = tag; ordy[0] = 1'b1;
    @(posedge clk); #1 iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk({nm, "_early"}, ov[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_vld"}, ov[0], 1'b1);
    chk({nm, "_sum"}, os[0], es);
    chk({nm, "_flags"}, {oc[0], oo[0], otag[0]}, {ec, eo, tag});
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int i);
    int          c, a0;
    logic [31:0] msb;
    c   = 0;
    a0  = n_acc[i];
    msb = 32'h1 << (cw(i) - 1);
    while (n_acc[i] - a0 < 10000 && c < 40000) begin
      iv[i]   = ($urandom_range(0, 3) != 0);
      ia[i]   = $urandom;
      ib[i]   = $urandom;
      isub[i] = $urandom_range(0, 1);
      ici[i]  = $urandom_range(0, 1);
      itag[i] = 4'($urandom);
      ordy[i] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: ia[i] = '0;
          1: ia[i] = '1;
          2: ia[i] = msb;
          default: ia[i] = msb - 1;
        endcase
      end
      if ($urandom_range(0, 7) == 0) ib[i] = (ib[i][0]) ? '1 : 32'h1;
      @(posedge clk); #1;
      c++;
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    chk($sformatf("c%0d_rand_ops", i), (n_acc[i] - a0 >= 10000), 1);
  endtask

  initial begin
    int k, left, n0;
    logic seen;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; ia[i] = 0; ib[i] = 0; isub[i] = 0; ici[i] = 0; itag[i] = 0; ordy[i] = 1;
      n_cons[i] = 0; n_acc[i] = 0; qdep[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) chk($sformatf("c%0d_rel_ready", i), ir[i], 1'b1);
    @(posedge clk); #1;

    dir_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 4'd3, 32'h0000_0000, 1, 0);
    dir_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1, 0, 4'd1, 32'h7FFF_FFFF, 1, 1);
    dir_op("sub_borrow",32'h0000_0000, 32'h0000_0001, 1, 0, 4'd2, 32'hFFFF_FFFF, 0, 0);
    dir_op("seg_carry", 32'h00FF_FFFF, 32'h0000_0001, 0, 0, 4'd4, 32'h0100_0000, 0, 0);
    dir_op("add_ci_ovf",32'h7FFF_FFFF, 32'h0000_0000, 0, 1, 4'd5, 32'h8000_0000, 0, 1);
    dir_op("sub_ci_ign",32'h0000_0005, 32'h0000_0003, 1, 1, 4'd6, 32'h0000_0002, 1, 0);

    // Back-to-back tags 0..7 with a 3-cycle output stall after the first result.
    k = 0; left = 0; seen = 1'b0; n0 = n_cons[0];
    for (int c = 0; c < 60 && (n_cons[0] - n0) < 8; c++) begin
      iv[0] = (k < 8); ia[0] = $urandom; ib[0] = $urandom; isub[0] = $urandom_range(0, 1);
      ici[0] = $urandom_range(0, 1); itag[0] = 4'(k);
      ordy[0] = (left == 0);
      if (left > 0) left--;
      @(negedge clk);
      if (!ordy[0]) chk("stall_in_ready", ir[0], 1'b0);
      if (iv[0] && ir[0]) k++;
      if (!seen && ov[0]) begin seen = 1'b1; left = 3; end
      @(posedge clk); #1;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    chk("stall_all_out", n_cons[0] - n0, 8);

    // Reset with operations in flight: first result is at the output when reset hits.
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; ia[0] = 32'(i + 1); ib[0] = 32'd2; isub[0] = 0; ici[0] = 0; itag[0] = 4'(5 + i);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    chk("rst_pre_vld", {ov[0], os[0]}, {1'b1, 32'd3});
    rst_n = 1'b0;
    #1 chk("rst_async_outs", {ov[0], oc[0], oo[0], otag[0], os[0]}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rel_ready", ir[0], 1'b1);
    for (int i = 0; i < 6; i++) @(negedge clk) chk("rst_no_stale", ov[0], 1'b0);
    @(posedge clk); #1;
    dir_op("post_rst", 32'h1234_5678, 32'h1111_1111, 0, 1, 4'd9, 32'h2345_678A, 0, 0);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("c%0d_drained", i), qdep[i], 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cla_addsub_pipe.md
# cla_addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the k-means accelerator datapath (distance differences, centroid coordinate sums). Operands are split into SEG-bit lookahead segments, one segment resolved per pipeline stage with the inter-segment carry registered. A valid/ready handshake moves operands in and results out, and a tag rides along with each operation. Every cycle produces full-width sum, carry-out and signed overflow at a sustained rate of one operation per clock.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEG, WIDTH ≥ SEG.
- SEG, 8: lookahead segment width; NSEG = WIDTH/SEG pipeline stages.
- TAG_W, 4: sideband tag width (≥1).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0: A+B+in_ci; 1: A−B (in_ci ignored).
- in_ci  in  1  carry-in for add.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB (sub: 1 = no borrow).
- out_ovf  out  1  two's-complement signed overflow.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Sub: B inverted, carry-in forced to 1; add: B direct, carry-in = in_ci.
- Stage k (0..NSEG−1) computes segment k with full P/G lookahead (no ripple inside a segment) from the registered carry of stage k−1 (stage 0: effective carry-in).
- Each stage registers: completed low sum segments, carry, unconsumed upper operand segments (already B-inverted), tag, valid bit. Bubbles carried as valid=0.
- Last stage also yields cout = carry out of bit WIDTH−1 and ovf = carry into MSB XOR carry out of MSB.
- Arithmetic modulo 2^WIDTH; no saturation.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. When advance=0 every stage register, including outputs, holds.
- Input accepted iff in_valid && in_ready; output consumed iff out_valid && out_ready.

## Timing
- Latency: result for an operation accepted at edge t appears (out_valid=1) after edge t+NSEG−1, i.e. NSEG register stages, when no stall occurs; each stall cycle adds one.
- Throughput: one op/cycle while out_ready=1.
- in_ready is combinational from out_valid/out_ready only (no path from in_valid).
- Output stable (sum, cout, ovf, tag) while out_valid=1 and out_ready=0.
- Reset (async assert, sync-release handled upstream): all valid bits 0, out_sum 0, out_cout 0, out_ovf 0, out_tag 0; in_ready=1 on first cycle after release. In-flight operations are discarded, never emitted.
- SEG=WIDTH: single stage, latency 1.
- Simultaneous accept and consume in the same cycle: both occur, no bubble.

## Structure
- Package cla_pkg: function nseg(WIDTH,SEG); elaboration check that WIDTH%SEG==0; stage-record struct {valid, tag, partial sum, carry, upper operands}.
- Sub-module cla_segment: combinational SEG-bit lookahead (inputs a, b, ci; outputs sum, co, c_msb_in for overflow), instanced once per stage via generate.
- Top holds the stage register array and stall logic only.

## Test plan
WIDTH=32, SEG=8 (latency 4) unless noted.
- Add 0xFFFFFFFF+0x00000001, ci=0, tag 3 -> after 4 cycles out_sum=0x00000000, cout=1, ovf=0, tag=3.
- Sub 0x80000000−0x00000001 -> sum 0x7FFFFFFF, cout=1, ovf=1; sub 0x00000000−0x00000001 -> 0xFFFFFFFF, cout=0, ovf=0.
- Cross-segment carry: 0x00FFFFFF+0x00000001 -> 0x01000000; 0x7FFFFFFF+0x00000000 ci=1 -> 0x80000000, ovf=1.
- Back-to-back tags 0..7, out_ready low for 3 cycles after first result -> in_ready low during stall, output held, all 8 results in order, none lost/duplicated.
- Reset asserted with 3 ops in flight -> out_valid 0 immediately, all outputs 0; after release no stale result, next op returns correctly.
- WIDTH=24, SEG=8 and WIDTH=SEG=16 -> random 10k ops vs reference model; latency 3 and 1 respectively.
